icache_assoc: RTL and testbench
===============================

// Module: icache_assoc
// PURPOSE
//  Parametrised set-associative instruction cache between fetch and the memory-side refill path.
//  Entries are keyed by halfword-aligned PC and hold one 32-bit inst plus an is_c flag.
//  Lookup is registered (1-cycle), which makes the data arrays BRAM-inferable.
//  Adds tree-PLRU replacement, fence.i flush and hit/miss counters.
// PARAMETERS
//  WAYS       2   associativity; power of 2, 1..8 (1 = direct-mapped, no PLRU state)
//  SET_WIDTH  7   log2(sets); index = addr[SET_WIDTH:1], tag = addr[31:SET_WIDTH+1]
//  CNT_WIDTH  32  width of the statistics counters
// PORTS
//  clk_in        in   1          system clock
//  rst_in        in   1          reset; asynchronous, active-high
//  rdy_in        in   1          global enable; when low, all state holds
//  flush_in      in   1          fence.i: invalidate every entry
//  get_ready     in   1          lookup request this cycle
//  get_addr      in   32         lookup PC (bit 0 ignored)
//  get_valid     out  1          registered: a lookup result is presented
//  get_hit       out  1          registered: result is a hit (meaningful only with get_valid)
//  get_inst      out  32         registered instruction (undefined on miss)
//  get_is_c      out  1          registered compressed flag
//  wr_ready      in   1          fill request
//  wr_addr       in   32         fill PC
//  wr_inst       in   32         fill instruction
//  wr_is_c       in   1          fill compressed flag
//  hit_cnt       out  CNT_WIDTH  lookups that hit; saturating
//  miss_cnt      out  CNT_WIDTH  lookups that missed; saturating
// BEHAVIOUR
//  Reset (async):
//   - get_valid, get_hit, get_inst, get_is_c = 0; all valid bits = 0; PLRU = 0; counters = 0.
//   - Tag and data arrays are not reset.
//  A cycle is active iff rdy_in = 1. Inactive cycles change nothing; registered outputs hold.
//  Lookup (active, get_ready):
//   - The next edge sets get_valid = 1, get_hit = any way with valid and tag match,
//     get_inst and get_is_c from the hitting way.
//   - Latency is exactly 1 cycle; back-to-back lookups are accepted every cycle.
//  Active cycle without get_ready: get_valid = 0 at the next edge.
//  Fill (active, wr_ready):
//   - Way selection: the matching way if tag already present (overwrite);
//     else the lowest-index invalid way; else the PLRU victim.
//   - Fill writes valid, tag, data and is_c, then marks that way MRU.
//  PLRU (tree of WAYS-1 bits per set):
//   - Lookup hit updates the hit way to MRU at the same edge as the response.
//   - Lookup and fill in the same set and cycle: the fill update is applied last.
//  Lookup and fill to the same address in the same cycle: read-before-write.
//   - The lookup returns the old contents, or a miss if the entry was absent.
//   - The fill is visible from the next lookup on.
//  Flush (active, flush_in):
//   - All valid bits and PLRU bits clear at the edge.
//   - A coincident fill is dropped.
//   - A coincident lookup responds get_valid = 1, get_hit = 0 and counts as a miss.
//  Counters:
//   - Each responded lookup increments exactly one of hit_cnt / miss_cnt.
//   - Each counter saturates at all-ones.
//  Reset mid-operation: any pending response is lost; get_valid reads 0 immediately.
// STRUCTURE
//  Shared header icache_defs.vh:
//   - INST_WIDTH = 32, PC_WIDTH = 32
//   - tag-width macro TAG_W(SET_WIDTH) = 31 - SET_WIDTH
//   - log2 function shared with the dcache
//  One sub-module, plru_tree #(WAYS):
//   - Combinational victim encode from the tree bits.
//   - Next-state tree bits for a given accessed way.
//  The top holds the per-way arrays, the valid/PLRU flops, the response register and the counters.
// TESTING
//  1. Reset, then lookup 0x0000_1000 -> next cycle get_valid = 1, get_hit = 0, miss_cnt = 1.
//  2. Fill 0x1000 (inst 0x0000_0013), then lookup 0x1000 -> get_hit = 1, get_inst = 0x13, hit_cnt = 1.
//  3. WAYS = 2, SET_WIDTH = 7:
//     - Fill 0x1000, 0x2000, 0x3000 (same set); the third evicts 0x1000.
//     - Lookup 0x2000 then 0x1000 -> hit, then miss.
//     - Fill 0x4000 after a hit on 0x3000 -> evicts 0x2000.
//  4. Same cycle: fill and lookup 0x5002 on an empty cache -> miss.
//     - The next lookup of 0x5002 -> hit with is_c as written.
//  5. Fill 4 addresses, then flush_in plus a fill of 0x6000 in the same cycle.
//     - All 5 subsequent lookups miss.
//  6. Hold rdy_in = 0 for 3 cycles with get_ready = 1 -> outputs and counters frozen.
//     - Force miss_cnt near all-ones, then miss twice -> miss_cnt stays all-ones.

Source files
------------

// File: rtl/icache_assoc_pkg.sv
// Shared definitions for the set-associative instruction cache: widths,
// log2 helper and the tree-PLRU encode/update functions used by plru_tree.
package icache_assoc_pkg;

    localparam int INST_WIDTH = 32;
    localparam int PC_WIDTH   = 32;

    // Tree bits for up to 8 ways (7 nodes), heap order: node n at bit n-1.
    typedef logic [6:0] plru_t;
    typedef logic [2:0] way_t;

    typedef struct packed {
        logic                  valid;
        logic                  hit;
        logic [INST_WIDTH-1:0] inst;
        logic                  is_c;
    } resp_t;

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic int tag_w(input int set_width);
        return 31 - set_width;
    endfunction

    // Walk root to leaf along the way index (MSB first); each node is left
    // pointing away from the accessed side so it names the LRU half.
    function automatic plru_t plru_touch(input plru_t tree, input way_t way, input int levels);
        plru_t      t;
        logic [3:0] node;
        logic [2:0] idx;
        way_t       w;
        t    = tree;
        node = 4'd1;
        w    = way << (3 - levels);
        for (int l = 0; l < 3; l++) begin
            if (l < levels) begin
                idx    = node[2:0] - 3'd1;
                t[idx] = ~w[2];
                node   = {node[2:0], w[2]};
                w      = {w[1:0], 1'b0};
            end else begin
                node = node;
            end
        end
        return t;
    endfunction

    function automatic way_t plru_victim(input plru_t tree, input int levels);
        logic [3:0] node;
        logic [2:0] idx;
        node = 4'd1;
        for (int l = 0; l < 3; l++) begin
            if (l < levels) begin
                idx  = node[2:0] - 3'd1;
                node = {node[2:0], tree[idx]};
            end else begin
                node = node;
            end
        end
        return node[2:0] & ((3'd1 << levels) - 3'd1);
    endfunction

endpackage

// File: rtl/icache_assoc_plru_tree.sv
// Tree-PLRU helper for one set: applies an optional lookup touch, encodes
// the victim from that intermediate tree, then applies the fill touch.
module plru_tree
    import icache_assoc_pkg::*;
#(
    parameter int WAYS = 2
) (
    input  plru_t tree_in,
    input  logic  lk_en,
    input  way_t  lk_way,
    input  way_t  fill_way,
    output way_t  victim,
    output plru_t tree_next
);

    localparam int LV = clog2_f(WAYS);

    plru_t mid_s;

    // Lookup hit in the fill's set is applied first so the fill sees it.
    always_comb begin
        mid_s = lk_en ? plru_touch(tree_in, lk_way, LV) : tree_in;
    end

    assign victim    = plru_victim(mid_s, LV);
    assign tree_next = plru_touch(mid_s, fill_way, LV);

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with registered lookup, tree-PLRU
// replacement, fence.i flush and saturating hit/miss counters.
module icache_assoc
    import icache_assoc_pkg::*;
#(
    parameter int WAYS      = 2,
    parameter int SET_WIDTH = 7,
    parameter int CNT_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    input  logic                  get_ready,
    input  logic [31:0]           get_addr,
    output logic                  get_valid,
    output logic                  get_hit,
    output logic [31:0]           get_inst,
    output logic                  get_is_c,
    input  logic                  wr_ready,
    input  logic [31:0]           wr_addr,
    input  logic [31:0]           wr_inst,
    input  logic                  wr_is_c,
    output logic [CNT_WIDTH-1:0]  hit_cnt,
    output logic [CNT_WIDTH-1:0]  miss_cnt
);

    localparam int SETS = 1 << SET_WIDTH;
    localparam int TW   = tag_w(SET_WIDTH);
    localparam int LV   = clog2_f(WAYS);

    logic [TW-1:0]         tag_mem  [WAYS][SETS];
    logic [INST_WIDTH-1:0] data_mem [WAYS][SETS];
    logic                  isc_mem  [WAYS][SETS];
    logic [SETS-1:0]       valid_r  [WAYS];
    plru_t                 plru_r   [SETS];

    logic [SET_WIDTH-1:0]  lk_idx_s, wr_idx_s;
    logic [TW-1:0]         lk_tag_s, wr_tag_s;
    logic [WAYS-1:0]       hit_vec_s, match_vec_s, inv_vec_s;
    way_t                  lk_way_s, match_way_s, inv_way_s, victim_s, fill_way_s;
    logic                  lk_hit_s, lk_touch_s, fill_en_s, flush_en_s, lookup_en_s;
    resp_t                 lk_resp_s;
    plru_t                 lk_next_s, fill_next_s;
    logic                  addr_lsb_unused_s;

    assign lk_idx_s          = get_addr[SET_WIDTH:1];
    assign lk_tag_s          = get_addr[31:SET_WIDTH+1];
    assign wr_idx_s          = wr_addr[SET_WIDTH:1];
    assign wr_tag_s          = wr_addr[31:SET_WIDTH+1];
    assign addr_lsb_unused_s = get_addr[0] ^ wr_addr[0];

    assign lookup_en_s = rdy_in & get_ready;
    assign flush_en_s  = rdy_in & flush_in;
    assign fill_en_s   = rdy_in & wr_ready & ~flush_in;
    assign lk_touch_s  = lookup_en_s & lk_hit_s & ~flush_in;

    // Tag compare for lookup and fill; the lowest matching way wins.
    always_comb begin
        lk_way_s    = 3'd0;
        match_way_s = 3'd0;
        inv_way_s   = 3'd0;
        lk_resp_s   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_vec_s[w]   = valid_r[w][lk_idx_s] & (tag_mem[w][lk_idx_s] == lk_tag_s);
            match_vec_s[w] = valid_r[w][wr_idx_s] & (tag_mem[w][wr_idx_s] == wr_tag_s);
            inv_vec_s[w]   = ~valid_r[w][wr_idx_s];
            lk_way_s       = hit_vec_s[w]   ? way_t'(w) : lk_way_s;
            match_way_s    = match_vec_s[w] ? way_t'(w) : match_way_s;
            inv_way_s      = inv_vec_s[w]   ? way_t'(w) : inv_way_s;
            lk_resp_s.inst = hit_vec_s[w] ? data_mem[w][lk_idx_s] : lk_resp_s.inst;
            lk_resp_s.is_c = hit_vec_s[w] ? isc_mem[w][lk_idx_s]  : lk_resp_s.is_c;
        end
        lk_hit_s        = |hit_vec_s;
        lk_resp_s.valid = 1'b1;
        lk_resp_s.hit   = lk_hit_s & ~flush_in;
    end

    // Fill target: overwrite a match, else first free way, else PLRU victim.
    always_comb begin
        if (|match_vec_s) begin
            fill_way_s = match_way_s;
        end else if (|inv_vec_s) begin
            fill_way_s = inv_way_s;
        end else begin
            fill_way_s = victim_s;
        end
    end

    assign lk_next_s = plru_touch(plru_r[lk_idx_s], lk_way_s, LV);

    plru_tree #(.WAYS(WAYS)) u_plru (
        .tree_in   (plru_r[wr_idx_s]),
        .lk_en     (lk_touch_s && (lk_idx_s == wr_idx_s)),
        .lk_way    (lk_way_s),
        .fill_way  (fill_way_s),
        .victim    (victim_s),
        .tree_next (fill_next_s)
    );

    // Tag/data arrays carry no reset so they can map onto block RAM.
    always_ff @(posedge clk_in) begin
        if (fill_en_s) begin
            for (int w = 0; w < WAYS; w++) begin
                if (fill_way_s == way_t'(w)) begin
                    tag_mem[w][wr_idx_s]  <= wr_tag_s;
                    data_mem[w][wr_idx_s] <= wr_inst;
                    isc_mem[w][wr_idx_s]  <= wr_is_c;
                end
            end
        end
    end

    // Valid bits: cleared by reset or flush, set by a fill.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int w = 0; w < WAYS; w++) valid_r[w] <= '0;
        end else if (flush_en_s) begin
            for (int w = 0; w < WAYS; w++) valid_r[w] <= '0;
        end else if (fill_en_s) begin
            for (int w = 0; w < WAYS; w++) begin
                if (fill_way_s == way_t'(w)) valid_r[w][wr_idx_s] <= 1'b1;
            end
        end
    end

    // PLRU trees; a fill in the lookup's set is written last and wins.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int s = 0; s < SETS; s++) plru_r[s] <= 7'd0;
        end else if (flush_en_s) begin
            for (int s = 0; s < SETS; s++) plru_r[s] <= 7'd0;
        end else begin
            if (lk_touch_s) plru_r[lk_idx_s] <= lk_next_s;
            if (fill_en_s)  plru_r[wr_idx_s] <= fill_next_s;
        end
    end

    // Response register: one-cycle lookup latency.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            get_valid <= 1'b0;
            get_hit   <= 1'b0;
            get_inst  <= 32'd0;
            get_is_c  <= 1'b0;
        end else if (rdy_in) begin
            get_valid <= get_ready;
            if (get_ready) begin
                get_hit  <= lk_resp_s.hit;
                get_inst <= lk_resp_s.inst;
                get_is_c <= lk_resp_s.is_c;
            end
        end
    end

    // Saturating statistics; every responded lookup bumps exactly one.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (lookup_en_s) begin
            if (lk_resp_s.hit) begin
                if (!(&hit_cnt)) hit_cnt <= hit_cnt + CNT_WIDTH'(1);
            end else begin
                if (!(&miss_cnt)) miss_cnt <= miss_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc: directed scenarios with literal expectations plus
// randomized traffic checked each cycle against a 2-way true-LRU model.
module tb_icache_assoc;

    localparam int WAYS = 2;
    localparam int SW   = 7;
    localparam int CW   = 8;
    localparam int SETS = 1 << SW;

    logic          clk_in = 1'b0;
    logic          rst_in, rdy_in, flush_in, get_ready, wr_ready, wr_is_c;
    logic [31:0]   get_addr, wr_addr, wr_inst;
    logic          get_valid, get_hit, get_is_c;
    logic [31:0]   get_inst;
    logic [CW-1:0] hit_cnt, miss_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    icache_assoc #(.WAYS(WAYS), .SET_WIDTH(SW), .CNT_WIDTH(CW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .get_ready(get_ready), .get_addr(get_addr), .get_valid(get_valid),
        .get_hit(get_hit), .get_inst(get_inst), .get_is_c(get_is_c),
        .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_inst(wr_inst), .wr_is_c(wr_is_c),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each set is a pair of entries keyed by PC[31:1];
    // with two ways, tree-PLRU is plain LRU, so remember the MRU way.
    bit          m_v   [WAYS][SETS];
    logic [30:0] m_key [WAYS][SETS];
    logic [31:0] m_inst[WAYS][SETS];
    bit          m_c   [WAYS][SETS];
    int          m_mru [SETS];
    bit          e_valid, e_hit, e_c;
    logic [31:0] e_inst;
    int          e_hits, e_miss;

    always @(posedge clk_in or posedge rst_in) begin : model
        int hw, fw, ls, fs;
        if (rst_in) begin
            for (int s = 0; s < SETS; s++) begin
                m_mru[s] = 1;
                for (int w = 0; w < WAYS; w++) m_v[w][s] = 1'b0;
            end
            e_valid = 1'b0; e_hit = 1'b0; e_inst = 32'd0; e_c = 1'b0;
            e_hits = 0; e_miss = 0;
        end else if (rdy_in) begin
            ls = int'(get_addr[7:1]);
            fs = int'(wr_addr[7:1]);
            hw = -1;
            for (int w = 0; w < WAYS; w++)
                if (m_v[w][ls] && m_key[w][ls] == get_addr[31:1]) hw = w;
            e_valid = get_ready;
            if (get_ready) begin
                e_hit = (hw >= 0) && !flush_in;
                if (e_hit) begin
                    e_inst = m_inst[hw][ls];
                    e_c    = m_c[hw][ls];
                    e_hits = (e_hits == 255) ? 255 : e_hits + 1;
                end else begin
                    e_miss = (e_miss == 255) ? 255 : e_miss + 1;
                end
            end
            if (flush_in) begin
                for (int s = 0; s < SETS; s++) begin
                    m_mru[s] = 1;
                    for (int w = 0; w < WAYS; w++) m_v[w][s] = 1'b0;
                end
            end else begin
                if (get_ready && hw >= 0) m_mru[ls] = hw;
                if (wr_ready) begin
                    fw = -1;
                    for (int w = 0; w < WAYS; w++)
                        if (m_v[w][fs] && m_key[w][fs] == wr_addr[31:1]) fw = w;
                    if (fw < 0)
                        for (int w = WAYS - 1; w >= 0; w--) if (!m_v[w][fs]) fw = w;
                    if (fw < 0) fw = 1 - m_mru[fs];
                    m_v[fw][fs]    = 1'b1;
                    m_key[fw][fs]  = wr_addr[31:1];
                    m_inst[fw][fs] = wr_inst;
                    m_c[fw][fs]    = wr_is_c;
                    m_mru[fs]      = fw;
                end
            end
        end
    end

    // Compare process: outputs sampled on the falling edge.
    always @(negedge clk_in) begin
        if (cmp_en && !rst_in) begin
            chk("get_valid", 32'(get_valid), 32'(e_valid));
            if (e_valid) begin
                chk("get_hit", 32'(get_hit), 32'(e_hit));
                if (e_hit) begin
                    chk("get_inst", get_inst, e_inst);
                    chk("get_is_c", 32'(get_is_c), 32'(e_c));
                end
            end
            chk("hit_cnt", 32'(hit_cnt), 32'(e_hits));
            chk("miss_cnt", 32'(miss_cnt), 32'(e_miss));
        end
    end

    task automatic cyc(input logic gr, input logic [31:0] ga, input logic wr,
                       input logic [31:0] wa, input logic [31:0] wi, input logic wc,
                       input logic fl);
        get_ready = gr; get_addr = ga; wr_ready = wr; wr_addr = wa;
        wr_inst = wi; wr_is_c = wc; flush_in = fl;
        @(posedge clk_in); #1;
        get_ready = 1'b0; wr_ready = 1'b0; flush_in = 1'b0;
    endtask

    task automatic look(input logic [31:0] a);
        cyc(1'b1, a, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic fill(input logic [31:0] a, input logic [31:0] i, input logic c);
        cyc(1'b0, 32'd0, 1'b1, a, i, c, 1'b0);
    endtask

    function automatic logic [31:0] pool_addr();
        return (32'($urandom_range(0, 4)) << 8) | (32'($urandom_range(0, 3)) << 1)
               | 32'($urandom_range(0, 1));
    endfunction

    initial begin
        logic [31:0] flushed [5];
        flushed = '{32'h7000, 32'h7004, 32'h7008, 32'h700C, 32'h6000};
        rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; get_ready = 1'b0;
        wr_ready = 1'b0; wr_is_c = 1'b0; get_addr = 32'd0; wr_addr = 32'd0; wr_inst = 32'd0;
        repeat (2) @(posedge clk_in);
        #1;
        chk("reset_valid", 32'(get_valid), 32'd0);
        chk("reset_cnt", 32'(hit_cnt) + 32'(miss_cnt), 32'd0);
        rst_in = 1'b0;
        cmp_en = 1'b1;

        look(32'h1000);
        chk("t1_valid", 32'(get_valid), 32'd1);
        chk("t1_hit", 32'(get_hit), 32'd0);
        chk("t1_miss_cnt", 32'(miss_cnt), 32'd1);

        fill(32'h1000, 32'h0000_0013, 1'b0);
        look(32'h1000);
        chk("t2_hit", 32'(get_hit), 32'd1);
        chk("t2_inst", get_inst, 32'h13);
        chk("t2_hit_cnt", 32'(hit_cnt), 32'd1);

        fill(32'h2000, 32'h2222, 1'b0);
        fill(32'h3000, 32'h3333, 1'b0);
        look(32'h2000); chk("t3_hit_2000", 32'(get_hit), 32'd1);
        look(32'h1000); chk("t3_evicted_1000", 32'(get_hit), 32'd0);
        look(32'h3000); chk("t3_hit_3000", 32'(get_hit), 32'd1);
        fill(32'h4000, 32'h4444, 1'b0);
        look(32'h2000); chk("t3_evicted_2000", 32'(get_hit), 32'd0);
        look(32'h4000); chk("t3_inst_4000", get_inst, 32'h4444);

        cyc(1'b1, 32'h5002, 1'b1, 32'h5002, 32'hABCD, 1'b1, 1'b0);
        chk("t4_rbw_miss", 32'(get_hit), 32'd0);
        look(32'h5002);
        chk("t4_hit", 32'(get_hit), 32'd1);
        chk("t4_is_c", 32'(get_is_c), 32'd1);

        for (int i = 0; i < 4; i++) fill(flushed[i], 32'(i), 1'b0);
        cyc(1'b0, 32'd0, 1'b1, 32'h6000, 32'h66, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            look(flushed[i]);
            chk("t5_flush_miss", 32'(get_hit), 32'd0);
        end

        fill(32'h5002, 32'h77, 1'b1);
        look(32'h5002);
        rdy_in = 1'b0; get_ready = 1'b1; get_addr = 32'h1000;
        repeat (3) @(posedge clk_in);
        #1;
        chk("t6_frozen_valid", 32'(get_valid), 32'd1);
        chk("t6_frozen_hit_cnt", 32'(hit_cnt), 32'd6);
        chk("t6_frozen_miss_cnt", 32'(miss_cnt), 32'd9);
        rdy_in = 1'b1; get_ready = 1'b0;

        look(32'h4000);
        rst_in = 1'b1;
        #1;
        chk("mid_reset_valid", 32'(get_valid), 32'd0);
        chk("mid_reset_miss_cnt", 32'(miss_cnt), 32'd0);
        #1 rst_in = 1'b0;

        repeat (3000) begin
            rdy_in    = ($urandom_range(0, 9) != 0);
            get_ready = ($urandom_range(0, 9) < 7);
            get_addr  = pool_addr();
            wr_ready  = ($urandom_range(0, 9) < 4);
            wr_addr   = ($urandom_range(0, 4) == 0) ? get_addr : pool_addr();
            wr_inst   = $urandom;
            wr_is_c   = 1'($urandom_range(0, 1));
            flush_in  = ($urandom_range(0, 49) == 0);
            @(posedge clk_in); #1;
        end
        rdy_in = 1'b1; wr_ready = 1'b0; flush_in = 1'b0; get_ready = 1'b0;

        repeat (300) look(32'hF000_0000);
        chk("sat_miss_cnt", 32'(miss_cnt), 32'hFF);
        look(32'hF000_0000);
        look(32'hF000_0000);
        chk("sat_hold_miss_cnt", 32'(miss_cnt), 32'hFF);

        @(negedge clk_in);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
